tube_tdc_event_builder: RTL

Parametrised drift-tube TDC event builder: synchronises N_CH raw tube discriminator lines and the scintillator coincidence trigger to clk100, time-stamps the first hit per channel within a fixed window after each trigger, and packs each event into 16-bit words in an internal FIFO drained by the Raspberry Pi readout logic. It replaces the per-tube asynchronous capture and ad hoc FIFO transfer with a single-clock, resettable, zero-suppressing pipeline with deterministic latency and explicit overflow handling.

---
 rtl/tube_tdc_event_builder_if.sv | 10 +
 rtl/tube_tdc_event_builder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tube_tdc_event_builder_if.sv
// rtl/tube_tdc_event_builder_if.sv - readout port of the tube TDC event builder
interface tube_tdc_event_builder_if;
    logic [15:0] OTUBE;
    logic        RD_VALID;
    logic        RD_EN;
    logic        RD_EMPTY;

    modport master (output OTUBE, output RD_VALID, output RD_EMPTY, input RD_EN);
    modport slave  (input OTUBE, input RD_VALID, input RD_EMPTY, output RD_EN);
endinterface

// File: rtl/tube_tdc_event_builder.sv
// rtl/tube_tdc_event_builder.sv - drift-tube TDC event builder
// Synchronised trigger/hit capture, first-hit time stamps, event words packed into a FWFT FIFO.
module tube_tdc_event_builder #(
    parameter int N_CH          = 32,
    parameter int TW            = 8,
    parameter int WINDOW        = 200,
    parameter int ZERO_SUPPRESS = 1,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic                      clk100,
    input  logic                      rst_n,
    input  logic                      SCIN_COIN,
    input  logic [N_CH-1:0]           TUBE,
    tube_tdc_event_builder_if.master  rd,
    output logic                      busy,
    output logic                      overflowLight
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] NEED_C    = CW'(N_CH + 2);
    localparam logic [TW-1:0] CNT_LAST  = TW'(WINDOW - 1);
    localparam logic [8:0]    SLOT_LAST = 9'(N_CH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WINDOW, S_EMIT} state_t;

    // Bit N_CH carries the trigger, bits N_CH-1:0 the tubes.
    logic [N_CH:0]              sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, edge_q, edge_d;
    state_t                     state_q, state_d;
    logic [TW-1:0]              cntr_q, cntr_d;
    logic [8:0]                 slot_q, slot_d;
    logic [N_CH-1:0]            hit_valid_q, hit_valid_d;
    logic [N_CH-1:0][TW-1:0]    stamp_q, stamp_d;
    logic [7:0]                 hit_count_q, hit_count_d;
    logic [7:0]                 event_id_q, event_id_d;
    logic                       overflow_q, overflow_d;
    logic                       busy_q, busy_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              fifo_cnt_q, fifo_cnt_d;
    logic [15:0]                fifo_mem_q [FIFO_DEPTH];

    logic                       wr_en, rd_valid, rd_fire, sel_valid;
    logic [15:0]                wr_data;
    logic [TW-1:0]              sel_stamp;
    logic [8:0]                 ch_idx;

    assign rd_valid = (fifo_cnt_q != '0);
    assign rd_fire  = rd_valid && rd.RD_EN;

    always_comb begin
        ch_idx    = slot_q - 9'd1;
        sel_valid = 1'b0;
        sel_stamp = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx == 9'(c)) begin
                sel_valid = hit_valid_q[c];
                sel_stamp = stamp_q[c];
            end
        end
    end

    always_comb begin
        sync1_d     = {SCIN_COIN, TUBE};
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        edge_d      = sync2_q & ~sync3_q;
        state_d     = state_q;
        cntr_d      = cntr_q;
        slot_d      = slot_q;
        hit_valid_d = hit_valid_q;
        stamp_d     = stamp_q;
        hit_count_d = hit_count_q;
        event_id_d  = event_id_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
        wr_data     = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (edge_q[N_CH]) begin
                    state_d     = S_WINDOW;
                    cntr_d      = '0;
                    hit_valid_d = '0;
                    hit_count_d = 8'd0;
                end
            end
            S_WINDOW: begin
                cntr_d = cntr_q + TW'(1);
                for (int c = 0; c < N_CH; c++) begin
                    if (edge_q[c] && !hit_valid_q[c]) begin
                        stamp_d[c]     = cntr_q;
                        hit_valid_d[c] = 1'b1;
                        hit_count_d    = hit_count_d + 8'd1;
                    end
                end
                if (cntr_q == CNT_LAST) begin
                    slot_d = 9'd0;
                    // Whole event must fit, so EMIT never has to stall on a full FIFO.
                    if ((DEPTH_C - fifo_cnt_q) < NEED_C) begin
                        overflow_d = 1'b1;
                        event_id_d = event_id_q + 8'd1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                slot_d = slot_q + 9'd1;
                if (slot_q == 9'd0) begin
                    wr_en   = 1'b1;
                    wr_data = {8'hFF, event_id_q};
                end else if (slot_q == SLOT_LAST) begin
                    wr_en      = 1'b1;
                    wr_data    = {8'hFE, hit_count_q};
                    event_id_d = event_id_q + 8'd1;
                    state_d    = S_IDLE;
                end else if (sel_valid) begin
                    wr_en   = 1'b1;
                    wr_data = {ch_idx[7:0], 8'(sel_stamp)};
                end else if (ZERO_SUPPRESS == 0) begin
                    wr_en   = 1'b1;
                    wr_data = {ch_idx[7:0], 8'hFF};
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        wr_ptr_d   = wr_en   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CW'(wr_en) - CW'(rd_fire);
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            edge_q      <= '0;
            state_q     <= S_IDLE;
            cntr_q      <= '0;
            slot_q      <= '0;
            hit_valid_q <= '0;
            stamp_q     <= '0;
            hit_count_q <= '0;
            event_id_q  <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            edge_q      <= edge_d;
            state_q     <= state_d;
            cntr_q      <= cntr_d;
            slot_q      <= slot_d;
            hit_valid_q <= hit_valid_d;
            stamp_q     <= stamp_d;
            hit_count_q <= hit_count_d;
            event_id_q  <= event_id_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: the head word is masked until the count says it is valid.
    always_ff @(posedge clk100) begin
        if (wr_en) begin
            fifo_mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd.OTUBE       = rd_valid ? fifo_mem_q[rd_ptr_q] : 16'h0000;
    assign rd.RD_VALID    = rd_valid;
    assign rd.RD_EMPTY    = !rd_valid;
    assign busy           = busy_q;
    assign overflowLight  = overflow_q;
endmodule
